// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Types and constants shared by the UART transmitter and
//                receiver. Covers the FSM state encoding, the frame layout
//                constants and a parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmitter/receiver control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } uart_state_e;

  // The frame is start + 8 data + parity + stop
  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Even parity is the XOR of the data bits; odd parity is its complement
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Bit-period counter. It counts 0..CLKS_PER_BIT-1 while en_i
//                is high. tick_o is high for one cycle when the terminal
//                count is reached, and the counter then restarts at 0.
//                clr_i returns the counter to 0 and takes priority over en_i.
//  Ports       : clk    - clock
//                rst    - asynchronous active-low reset
//                en_i   - count enable
//                clr_i  - synchronous clear
//                tick_o - terminal-count strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int               c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] cnt_q;
  logic [c_CNT_W-1:0] cnt_d;

  // The tick qualifies with the enable, so a held count never produces
  // repeated strobes.
  assign tick_o = en_i && (cnt_q == c_TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART serial transmitter. A byte is sent as an 11-bit frame:
//                start, 8 data bits LSB-first, parity, and stop. Each bit is
//                held for CLKS_PER_BIT clocks. The request uses the
//                tx_start/clr_tx_start handshake with the APB block.
//  Ports       : clk          - clock
//                rst          - asynchronous active-low reset
//                tx_start     - request to send tx_data
//                tx_data      - byte to send, sampled in the LOAD cycle
//                txd          - serial output, idle high
//                busy         - high from the LOAD cycle through the DONE cycle
//                clr_tx_start - one-cycle pulse in LOAD telling APB to clear
//                               tx_start
//                done         - one-cycle pulse after the stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       busy,
  output logic       clr_tx_start,
  output logic       done
);

  localparam logic [3:0] c_LAST_BIT = 4'(FRAME_BITS - 1);

  uart_state_e           state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [3:0]            bit_cnt_q;
  logic                  busy_q;
  logic                  clr_q;
  logic                  done_q;
  logic                  baud_tick;

  // The counter runs only in SEND. It is held at zero otherwise, so the
  // start bit gets a full bit period.
  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == SEND),
    .clr_i  (state_q != SEND),
    .tick_o (baud_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '1;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          if (tx_start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
          end
        end
        LOAD: begin
          shift_q   <= {STOP_BIT, calc_parity(tx_data, PARITY_ODD), tx_data, START_BIT};
          bit_cnt_q <= '0;
          state_q   <= SEND;
        end
        SEND: begin
          if (baud_tick) begin
            // Shifting in ones leaves the register all-ones after the stop
            // bit. txd then rests high in DONE and IDLE without extra muxing.
            shift_q   <= {IDLE_LEVEL, shift_q[FRAME_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == c_LAST_BIT) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // txd comes straight from a flop, so reset drives the line high
  // immediately.
  assign txd          = shift_q[0];
  assign busy         = busy_q;
  assign clr_tx_start = clr_q;
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Testbench for uart_tx. It drives three instances:
//                  u0: 16 clocks per bit, even parity
//                  u1: 16 clocks per bit, odd parity
//                  u2: 2 clocks per bit, even parity
//                The stimulus pushes the expected 11-bit frames into a queue
//                for each instance. A monitor for each instance decodes txd
//                whenever a frame is loaded and checks it against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      tx_start;
  logic [2:0][7:0] tx_data;

  wire txd0, txd1, txd2;
  wire busy0, busy1, busy2;
  wire clr0, clr1, clr2;
  wire done0, done1, done2;

  wire [2:0] txd_v  = {txd2, txd1, txd0};
  wire [2:0] busy_v = {busy2, busy1, busy0};
  wire [2:0] clr_v  = {clr2, clr1, clr0};
  wire [2:0] done_v = {done2, done1, done0};

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(16), .PARITY_ODD(1'b0)) u0 (
    .clk(clk), .rst(rst), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .txd(txd0), .busy(busy0), .clr_tx_start(clr0), .done(done0));
  uart_tx #(.CLKS_PER_BIT(16), .PARITY_ODD(1'b1)) u1 (
    .clk(clk), .rst(rst), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .txd(txd1), .busy(busy1), .clr_tx_start(clr1), .done(done1));
  uart_tx #(.CLKS_PER_BIT(2), .PARITY_ODD(1'b0)) u2 (
    .clk(clk), .rst(rst), .tx_start(tx_start[2]), .tx_data(tx_data[2]),
    .txd(txd2), .busy(busy2), .clr_tx_start(clr2), .done(done2));

  int n_vec = 0;
  int n_err = 0;
  int fs0 = 0, fs1 = 0, fs2 = 0;
  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic [10:0] exp_q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [10:0] f);
    case (idx)
      0: exp_q0.push_back(f);
      1: exp_q1.push_back(f);
      default: exp_q2.push_back(f);
    endcase
  endtask

  // Monitor: decodes one frame per LOAD cycle seen on clr_tx_start
  task automatic monitor(input int idx, input int cpb);
    logic [10:0] exp;
    bit          have;
    bit          abort;
    bit          busy_ok;
    bit          clr_ok;
    logic        seen;
    forever begin
      @(negedge clk);
      if (rst && clr_v[idx]) begin
        have = 1'b0;
        exp  = '1;
        case (idx)
          0: if (exp_q0.size() > 0) begin exp = exp_q0.pop_front(); have = 1'b1; end
          1: if (exp_q1.size() > 0) begin exp = exp_q1.pop_front(); have = 1'b1; end
          default: if (exp_q2.size() > 0) begin exp = exp_q2.pop_front(); have = 1'b1; end
        endcase
        check($sformatf("u%0d frame_expected", idx), 32'(have), 32'd1);
        check($sformatf("u%0d load_txd_high", idx), 32'(txd_v[idx]), 32'd1);
        abort   = 1'b0;
        busy_ok = 1'b1;
        clr_ok  = 1'b1;
        for (int b = 0; b < 11 && !abort; b++) begin
          seen = exp[b];
          for (int c = 0; c < cpb && !abort; c++) begin
            @(negedge clk);
            if (!rst) begin
              abort = 1'b1;
            end else begin
              if (txd_v[idx] !== exp[b]) seen = txd_v[idx];
              if (busy_v[idx] !== 1'b1) busy_ok = 1'b0;
              if (clr_v[idx] !== 1'b0 || done_v[idx] !== 1'b0) clr_ok = 1'b0;
            end
          end
          if (!abort && have)
            check($sformatf("u%0d bit%0d", idx, b), 32'(seen), 32'(exp[b]));
        end
        if (!abort) begin
          check($sformatf("u%0d busy_during_frame", idx), 32'(busy_ok), 32'd1);
          check($sformatf("u%0d no_stray_clr_or_done", idx), 32'(clr_ok), 32'd1);
          @(negedge clk);
          check($sformatf("u%0d done_pulse", idx), 32'(done_v[idx]), 32'd1);
          check($sformatf("u%0d done_txd_busy", idx), 32'({txd_v[idx], busy_v[idx]}), 32'd3);
          @(negedge clk);
          check($sformatf("u%0d idle_after_done", idx), 32'({done_v[idx], busy_v[idx]}), 32'd0);
          case (idx)
            0: fs0++;
            1: fs1++;
            default: fs2++;
          endcase
        end
      end
    end
  endtask

  initial monitor(0, 16);
  initial monitor(1, 16);
  initial monitor(2, 2);

  // Waits at negedges for clr (which=0) or done (which=1); k = cycles waited
  task automatic wait_sig(input int idx, input int which, input int budget,
                          input string name, output int k);
    k = 0;
    while (k < budget && ((which == 0) ? clr_v[idx] : done_v[idx]) !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'((which == 0) ? clr_v[idx] : done_v[idx]), 32'd1);
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic [10:0] f, input int cpb);
    int k;
    @(negedge clk);
    push(idx, f);
    tx_data[idx]  = d;
    tx_start[idx] = 1'b1;
    @(negedge clk);
    check($sformatf("u%0d clr_pulse", idx), 32'(clr_v[idx]), 32'd1);
    tx_start[idx] = 1'b0;
    wait_sig(idx, 1, 400, $sformatf("u%0d done_seen", idx), k);
    check($sformatf("u%0d done_latency", idx), 32'(k), 32'(1 + 11 * cpb));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  quiet;
    rst      = 1'b0;
    tx_start = '0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    check("reset txd", 32'(txd_v), 32'h7);
    check("reset busy", 32'(busy_v), 32'h0);
    check("reset clr", 32'(clr_v), 32'h0);
    check("reset done", 32'(done_v), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frames and parity cases
    send(0, 8'hA5, 11'h54A, 16);
    send(1, 8'h00, 11'h600, 16);
    send(0, 8'hFF, 11'h5FE, 16);
    send(1, 8'h80, 11'h500, 16);
    // Two clocks per bit
    send(2, 8'h5A, 11'h4B4, 2);
    send(2, 8'hC3, 11'h586, 2);
    send(2, 8'h07, 11'h60E, 2);

    // Back-to-back: tx_start held, data changed after the first LOAD
    @(negedge clk);
    push(0, 11'h478);
    push(0, 11'h602);
    tx_data[0]  = 8'h3C;
    tx_start[0] = 1'b1;
    wait_sig(0, 0, 10, "b2b first clr", k);
    @(negedge clk);
    tx_data[0] = 8'h01;
    wait_sig(0, 1, 400, "b2b first done", k);
    wait_sig(0, 0, 10, "b2b second clr", k);
    check("b2b gap after done", 32'(k), 32'd2);
    tx_start[0] = 1'b0;
    wait_sig(0, 1, 400, "b2b second done", k);
    @(negedge clk);

    // Data change and tx_start pulse mid-frame must not disturb anything
    @(negedge clk);
    push(0, 11'h52C);
    tx_data[0]  = 8'h96;
    tx_start[0] = 1'b1;
    @(negedge clk);
    check("midframe clr_pulse", 32'(clr_v[0]), 32'd1);
    tx_start[0] = 1'b0;
    repeat (40) @(negedge clk);
    tx_data[0]  = 8'h00;
    tx_start[0] = 1'b1;
    @(negedge clk);
    tx_start[0] = 1'b0;
    wait_sig(0, 1, 400, "midframe done", k);
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (busy_v[0] !== 1'b0 || clr_v[0] !== 1'b0) quiet = 1'b0;
    end
    check("no second frame", 32'(quiet), 32'd1);

    // Asynchronous reset during data bit 3 (fifth bit on the line)
    @(negedge clk);
    push(0, 11'h54A);
    tx_data[0]  = 8'hA5;
    tx_start[0] = 1'b1;
    @(negedge clk);
    tx_start[0] = 1'b0;
    repeat (1 + 4 * 16 + 5) @(negedge clk);
    check("pre-reset txd", 32'(txd_v[0]), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("async reset txd", 32'(txd_v[0]), 32'd1);
    check("async reset busy", 32'(busy_v[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || txd_v[0] !== 1'b1) quiet = 1'b0;
    end
    check("no completion after reset", 32'(quiet), 32'd1);
    send(0, 8'hA5, 11'h54A, 16);

    repeat (5) @(negedge clk);
    check("u0 queue drained", 32'(exp_q0.size()), 32'd0);
    check("u1 queue drained", 32'(exp_q1.size()), 32'd0);
    check("u2 queue drained", 32'(exp_q2.size()), 32'd0);
    check("u0 frames", 32'(fs0), 32'd6);
    check("u1 frames", 32'(fs1), 32'd2);
    check("u2 frames", 32'(fs2), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
